// File: rtl/ir_rx_cmd_queue.sv
// ir_rx_cmd_queue: validates NEC frames and queues address/command pairs in a fall-through FIFO
module ir_rx_cmd_queue #(
   parameter int         FIFO_DEPTH      = 4,
   parameter bit         STRICT_ADDR_INV = 1'b1,
   parameter bit         ADDR_FILTER_EN  = 1'b0,
   parameter logic [7:0] FILTER_ADDR     = 8'h00
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          data_ready,
   input  logic [31:0]                   data_in,
   output logic                          cmd_valid,
   input  logic                          cmd_ready,
   output logic [7:0]                    cmd_addr,
   output logic [7:0]                    cmd_data,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic [31:0]                   last_frame,
   output logic [15:0]                   good_count,
   output logic                          err_check,
   output logic                          err_overflow
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = FIFO_DEPTH[CW-1:0];
   typedef enum logic [1:0] {IDLE, CHECK, COMMIT} state_t;
   state_t state;
   logic dr_q, data_ok, addr_ok, filt_ok, pop, push, full, frame_good, edge_seen;
   logic [31:0] frame_q;
   logic [15:0] mem [FIFO_DEPTH];
   logic [15:0] hold;
   logic [AW-1:0] rd_ptr, wr_ptr;
   always_comb begin
      edge_seen = data_ready && !dr_q;
      full = fifo_count == DEPTH_C;
      pop = cmd_valid && cmd_ready;
      frame_good = state == COMMIT && data_ok && addr_ok && filt_ok;
      push = frame_good && (!full || pop);
   end
   assign cmd_valid = fifo_count != '0;
   assign {cmd_addr, cmd_data} = cmd_valid ? mem[rd_ptr] : hold;
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         dr_q <= 1'b1;
         frame_q <= '0;
         data_ok <= 1'b0;
         addr_ok <= 1'b0;
         filt_ok <= 1'b0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         fifo_count <= '0;
         hold <= '0;
         last_frame <= '0;
         good_count <= '0;
         err_check <= 1'b0;
         err_overflow <= 1'b0;
      end else begin
         dr_q <= data_ready;
         state <= state == IDLE ? (edge_seen ? CHECK : IDLE) : state == CHECK ? COMMIT : IDLE;
         if (state == IDLE && edge_seen) frame_q <= data_in;
         if (state == CHECK) begin
            data_ok <= frame_q[23:16] == ~frame_q[31:24];
            addr_ok <= !STRICT_ADDR_INV || frame_q[7:0] == ~frame_q[15:8];
            filt_ok <= !ADDR_FILTER_EN || frame_q[7:0] == FILTER_ADDR;
         end
         err_check <= state == COMMIT && !(data_ok && addr_ok);
         err_overflow <= frame_good && full && !pop;
         if (pop) begin
            hold <= mem[rd_ptr];
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
            last_frame <= frame_q;
            good_count <= good_count + 16'd1;
         end
         fifo_count <= fifo_count + CW'(push) - CW'(pop);
      end
   end
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= {frame_q[7:0], frame_q[23:16]};
endmodule

// File: tb/tb_ir_rx_cmd_queue.sv
// tb_ir_rx_cmd_queue: directed and random checks of three parameter variants against a frame-level model
module tb_ir_rx_cmd_queue;
   localparam int DEPTH = 4;
   localparam bit STRICT [3] = '{1'b1, 1'b1, 1'b0};
   localparam bit FILT [3] = '{1'b0, 1'b1, 1'b0};
   logic clk = 1'b0, rst = 1'b1, data_ready = 1'b1, cmd_ready = 1'b0;
   logic [31:0] data_in = 32'h0;
   logic v [3], ec [3], eo [3];
   logic [7:0] ca [3], cd [3];
   logic [2:0] cnt [3];
   logic [31:0] lf [3];
   logic [15:0] gc [3];
   int errors = 0, checks = 0;
   logic [15:0] mq [3][$];
   logic [15:0] mhold [3], mgc [3];
   logic [31:0] mlf [3];
   logic mec [3], meo [3];
   bit busy, prev;
   int stage;
   logic [31:0] pend;
   always #5 clk = ~clk;
   ir_rx_cmd_queue u_dut (.clk(clk), .rst(rst), .data_ready(data_ready), .data_in(data_in),
      .cmd_valid(v[0]), .cmd_ready(cmd_ready), .cmd_addr(ca[0]), .cmd_data(cd[0]), .fifo_count(cnt[0]),
      .last_frame(lf[0]), .good_count(gc[0]), .err_check(ec[0]), .err_overflow(eo[0]));
   ir_rx_cmd_queue #(.ADDR_FILTER_EN(1'b1), .FILTER_ADDR(8'h01)) u_flt (.clk(clk), .rst(rst),
      .data_ready(data_ready), .data_in(data_in), .cmd_valid(v[1]), .cmd_ready(cmd_ready),
      .cmd_addr(ca[1]), .cmd_data(cd[1]), .fifo_count(cnt[1]), .last_frame(lf[1]), .good_count(gc[1]),
      .err_check(ec[1]), .err_overflow(eo[1]));
   ir_rx_cmd_queue #(.STRICT_ADDR_INV(1'b0)) u_ext (.clk(clk), .rst(rst), .data_ready(data_ready),
      .data_in(data_in), .cmd_valid(v[2]), .cmd_ready(cmd_ready), .cmd_addr(ca[2]), .cmd_data(cd[2]),
      .fifo_count(cnt[2]), .last_frame(lf[2]), .good_count(gc[2]), .err_check(ec[2]), .err_overflow(eo[2]));
   function automatic logic [31:0] mk(input logic [7:0] a, input logic [7:0] c);
      return {~c, c, ~a, a};
   endfunction
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic model();
      bit commit, pop, dok, aok, fok, do_push;
      if (rst) begin
         for (int c = 0; c < 3; c++) begin
            mq[c].delete();
            mhold[c] = '0; mgc[c] = '0; mlf[c] = '0; mec[c] = 1'b0; meo[c] = 1'b0;
         end
         busy = 1'b0;
         prev = 1'b1;
      end else begin
         commit = busy && stage == 2;
         for (int c = 0; c < 3; c++) begin
            mec[c] = 1'b0;
            meo[c] = 1'b0;
            do_push = 1'b0;
            pop = mq[c].size() != 0 && cmd_ready;
            if (commit) begin
               dok = pend[23:16] == ~pend[31:24];
               aok = !STRICT[c] || pend[7:0] == ~pend[15:8];
               fok = !FILT[c] || pend[7:0] == 8'h01;
               if (!(dok && aok)) mec[c] = 1'b1;
               else if (fok) begin
                  if (mq[c].size() == DEPTH && !pop) meo[c] = 1'b1;
                  else do_push = 1'b1;
               end
            end
            if (pop) mhold[c] = mq[c].pop_front();
            if (do_push) begin
               mq[c].push_back({pend[7:0], pend[23:16]});
               mgc[c] = mgc[c] + 16'd1;
               mlf[c] = pend;
            end
         end
         if (busy) begin
            if (stage == 2) busy = 1'b0;
            else stage = 2;
         end else if (data_ready && !prev) begin
            busy = 1'b1;
            stage = 1;
            pend = data_in;
         end
         prev = data_ready;
      end
   endtask
   task automatic check_all();
      for (int c = 0; c < 3; c++) begin
         logic [15:0] head;
         head = mq[c].size() != 0 ? mq[c][0] : mhold[c];
         chk($sformatf("c%0d_valid", c), 32'(v[c]), 32'(mq[c].size() != 0));
         chk($sformatf("c%0d_count", c), 32'(cnt[c]), 32'(mq[c].size()));
         chk($sformatf("c%0d_addr", c), 32'(ca[c]), 32'(head[15:8]));
         chk($sformatf("c%0d_data", c), 32'(cd[c]), 32'(head[7:0]));
         chk($sformatf("c%0d_last", c), lf[c], mlf[c]);
         chk($sformatf("c%0d_good", c), 32'(gc[c]), 32'(mgc[c]));
         chk($sformatf("c%0d_errc", c), 32'(ec[c]), 32'(mec[c]));
         chk($sformatf("c%0d_erro", c), 32'(eo[c]), 32'(meo[c]));
      end
   endtask
   task automatic tick();
      model();
      @(posedge clk);
      #1;
      check_all();
   endtask
   task automatic frame(input logic [31:0] f, input logic rdy);
      data_ready = 1'b0;
      tick();
      data_in = f;
      data_ready = 1'b1;
      tick();
      tick();
      cmd_ready = rdy;
      tick();
      cmd_ready = 1'b0;
      data_ready = 1'b0;
   endtask
   task automatic drain(input int n);
      for (int i = 0; i < n; i++) begin
         cmd_ready = 1'b1;
         tick();
      end
      cmd_ready = 1'b0;
   endtask
   initial begin
      logic [7:0] a, c, ia, id;
      data_in = mk(8'h01, 8'h1A);
      tick();
      tick();
      rst = 1'b0;
      repeat (3) tick();
      chk("t6_high_at_release_count", 32'(cnt[0]), 32'd0);
      chk("t6_high_at_release_good", 32'(gc[0]), 32'd0);
      frame(32'hE51AFE01, 1'b0);
      chk("t1_valid", 32'(v[0]), 32'd1);
      chk("t1_addr", 32'(ca[0]), 32'h01);
      chk("t1_data", 32'(cd[0]), 32'h1A);
      chk("t1_good", 32'(gc[0]), 32'd1);
      chk("t1_last", lf[0], 32'hE51AFE01);
      drain(1);
      frame(32'hE51BFE01, 1'b0);
      chk("t2_errc", 32'(ec[0]), 32'd1);
      chk("t2_count", 32'(cnt[0]), 32'd0);
      chk("t2_good", 32'(gc[0]), 32'd1);
      for (int k = 1; k <= 5; k++) frame(mk(8'h01, 8'(k)), 1'b0);
      chk("t3_overflow", 32'(eo[0]), 32'd1);
      chk("t3_count", 32'(cnt[0]), 32'd4);
      for (int k = 1; k <= 4; k++) begin
         chk("t3_drain", 32'(cd[0]), 32'(k));
         drain(1);
      end
      chk("hold_data", 32'(cd[0]), 32'h04);
      chk("hold_valid", 32'(v[0]), 32'd0);
      for (int k = 8'h11; k <= 8'h14; k++) frame(mk(8'h01, 8'(k)), 1'b0);
      frame(mk(8'h01, 8'h15), 1'b1);
      chk("t4_no_overflow", 32'(eo[0]), 32'd0);
      chk("t4_count", 32'(cnt[0]), 32'd4);
      chk("t4_head", 32'(cd[0]), 32'h12);
      for (int k = 8'h12; k <= 8'h15; k++) begin
         chk("t4_drain", 32'(cd[0]), 32'(k));
         drain(1);
      end
      frame(32'hE51AFD02, 1'b0);
      chk("t5_flt_count", 32'(cnt[1]), 32'd0);
      chk("t5_flt_errc", 32'(ec[1]), 32'd0);
      chk("t5_flt_erro", 32'(eo[1]), 32'd0);
      chk("t5_def_count", 32'(cnt[0]), 32'd1);
      frame(32'hE51A0001, 1'b0);
      chk("t5_strict_errc", 32'(ec[0]), 32'd1);
      chk("t5_ext_errc", 32'(ec[2]), 32'd0);
      chk("t5_ext_count", 32'(cnt[2]), 32'd2);
      chk("t5_ext_last", lf[2], 32'hE51A0001);
      drain(2);
      frame(mk(8'h01, 8'h33), 1'b0);
      data_ready = 1'b0;
      tick();
      data_in = mk(8'h01, 8'h44);
      data_ready = 1'b1;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      tick();
      chk("t6_rst_count", 32'(cnt[0]), 32'd0);
      chk("t6_rst_good", 32'(gc[0]), 32'd0);
      chk("t6_rst_errc", 32'(ec[0]), 32'd0);
      frame(mk(8'h01, 8'h55), 1'b0);
      chk("t6_after_good", 32'(gc[0]), 32'd1);
      chk("t6_after_data", 32'(cd[0]), 32'h55);
      drain(1);
      for (int i = 0; i < 600; i++) begin
         rst = $urandom % 150 == 0;
         data_ready = $urandom % 3 == 0;
         a = 8'($urandom_range(0, 3));
         c = 8'($urandom);
         ia = ($urandom % 4 != 0) ? ~a : 8'($urandom);
         id = ($urandom % 5 != 0) ? ~c : 8'($urandom);
         data_in = {id, c, ia, a};
         cmd_ready = $urandom % 2 == 0;
         tick();
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
